// File: rtl/signed_sub_with_saturation_pipe.sv
// Two-stage valid/ready pipeline computing the saturated signed difference a - b.
// Optional saturation event counter (sat_cnt) is built when SIGNED_SUB_SAT_COUNT_EN is defined.
module signed_sub_with_saturation_pipe #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_vld,
  output logic             up_rdy,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             down_vld,
  input  logic             down_rdy,
  output logic [WIDTH-1:0] diff,
  output logic             sat
`ifdef SIGNED_SUB_SAT_COUNT_EN
  ,
  output logic [7:0]       sat_cnt
`endif
);

  localparam int unsigned RAW_W = WIDTH + 1;
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic             en;
  logic             s1_vld_q, s1_vld_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [RAW_W-1:0] s1_raw_q, s1_raw_d;
  logic             down_vld_d;
  logic [WIDTH-1:0] diff_d;
  logic             sat_d;
  logic             ovf;
  logic             unused_op_bits;

  // A full output register that is not being taken freezes the whole pipe.
  assign en     = !down_vld || down_rdy;
  assign up_rdy = en;

  // Only operand signs feed the overflow test; the low bits ride along for visibility.
  assign unused_op_bits = ^{s1_a_q[WIDTH-2:0], s1_b_q[WIDTH-2:0]};

  // Stage 1: capture operands and the sign-extended exact difference.
  always_comb begin
    s1_vld_d = s1_vld_q;
    s1_a_d   = s1_a_q;
    s1_b_d   = s1_b_q;
    s1_raw_d = s1_raw_q;
    if (en) begin
      s1_vld_d = up_vld;
      s1_a_d   = a;
      s1_b_d   = b;
      s1_raw_d = RAW_W'({a[WIDTH-1], a}) - RAW_W'({b[WIDTH-1], b});
    end
  end

  // Stage 2: clamp when the truncated sign disagrees with the minuend on mixed-sign operands.
  always_comb begin
    ovf        = (s1_a_q[WIDTH-1] != s1_b_q[WIDTH-1]) &&
                 (s1_raw_q[WIDTH-1] != s1_a_q[WIDTH-1]);
    down_vld_d = down_vld;
    diff_d     = diff;
    sat_d      = sat;
    if (en) begin
      down_vld_d = s1_vld_q;
      sat_d      = ovf;
      if (ovf) begin
        diff_d = s1_raw_q[WIDTH] ? MIN_NEG : MAX_POS;
      end else begin
        diff_d = s1_raw_q[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_raw_q <= '0;
      down_vld <= 1'b0;
      diff     <= '0;
      sat      <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_a_q   <= s1_a_d;
      s1_b_q   <= s1_b_d;
      s1_raw_q <= s1_raw_d;
      down_vld <= down_vld_d;
      diff     <= diff_d;
      sat      <= sat_d;
    end
  end

`ifdef SIGNED_SUB_SAT_COUNT_EN
  logic [7:0] sat_cnt_d;

  // Count delivered clamped results, sticking at full scale.
  always_comb begin
    sat_cnt_d = sat_cnt;
    if (down_vld && down_rdy && sat && (sat_cnt != 8'hFF)) begin
      sat_cnt_d = sat_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt <= 8'd0;
    end else begin
      sat_cnt <= sat_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_signed_sub_with_saturation_pipe.sv
// Self-checking bench for signed_sub_with_saturation_pipe (WIDTH=4): directed table,
// stall/reset sequences, exhaustive sweep and randomized traffic against a clamped integer model.
module tb_signed_sub_with_saturation_pipe;

  localparam int unsigned W = 4;
  localparam int MAXV = (1 <<< (W - 1)) - 1;
  localparam int MINV = -(1 <<< (W - 1));

  logic         clk = 1'b0;
  logic         rst_n;
  logic         up_vld;
  logic         up_rdy;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         down_vld;
  logic         down_rdy;
  logic [W-1:0] diff;
  logic         sat;
`ifdef SIGNED_SUB_SAT_COUNT_EN
  logic [7:0]   sat_cnt;
  int           exp_cnt = 0;
`endif

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         s;
  } vec_t;

  typedef struct {
    logic [W-1:0] d;
    logic         s;
  } res_t;

  res_t q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   delivered = 0;
  vec_t vt[12];

  always #5 clk = ~clk;

  signed_sub_with_saturation_pipe #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .up_vld  (up_vld),
    .up_rdy  (up_rdy),
    .a       (a),
    .b       (b),
    .down_vld(down_vld),
    .down_rdy(down_rdy),
    .diff    (diff),
    .sat     (sat)
`ifdef SIGNED_SUB_SAT_COUNT_EN
    ,
    .sat_cnt (sat_cnt)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer difference clamped to the signed W-bit range.
  function automatic res_t model(input logic [W-1:0] ai, input logic [W-1:0] bi);
    res_t r;
    int   sa, sb, x;
    sa = $signed(ai);
    sb = $signed(bi);
    x  = sa - sb;
    if (x > MAXV) begin
      r.d = W'(MAXV);
      r.s = 1'b1;
    end else if (x < MINV) begin
      r.d = W'(MINV);
      r.s = 1'b1;
    end else begin
      r.d = W'(x);
      r.s = 1'b0;
    end
    return r;
  endfunction

  task automatic sb_check();
    res_t r;
    chk("up_rdy", int'(up_rdy), int'(!down_vld || down_rdy));
    if (down_vld && down_rdy) begin
      chk("sb_not_empty", int'(q.size() != 0), 1);
      if (q.size() != 0) begin
        r = q.pop_front();
        chk("sb_diff", int'(diff), int'(r.d));
        chk("sb_sat", int'(sat), int'(r.s));
        delivered++;
`ifdef SIGNED_SUB_SAT_COUNT_EN
        if (r.s && exp_cnt < 255) exp_cnt++;
`endif
      end
    end
    if (up_vld && up_rdy) q.push_back(model(a, b));
  endtask

  // One clock: drive away from the edge, then account for the transfers of the coming edge.
  task automatic drive_cycle(input logic v, input logic [W-1:0] ai, input logic [W-1:0] bi,
                             input logic dr);
    @(posedge clk);
    #1;
    up_vld   = v;
    a        = ai;
    b        = bi;
    down_rdy = dr;
    #1;
    sb_check();
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && q.size() != 0; k++) drive_cycle(1'b0, '0, '0, 1'b1);
    chk("drain_empty", q.size(), 0);
`ifdef SIGNED_SUB_SAT_COUNT_EN
    chk("sat_cnt_model", int'(sat_cnt), exp_cnt);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL timeout reached @%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int idx;
    vt[0]  = '{W'(2),  W'(1),  W'(1),  1'b0};
    vt[1]  = '{W'(3),  W'(-5), W'(7),  1'b1};
    vt[2]  = '{W'(-3), W'(6),  W'(-8), 1'b1};
    vt[3]  = '{W'(-8), W'(-8), W'(0),  1'b0};
    vt[4]  = '{W'(-1), W'(7),  W'(-8), 1'b0};
    vt[5]  = '{W'(7),  W'(7),  W'(0),  1'b0};
    vt[6]  = '{W'(7),  W'(-8), W'(7),  1'b1};
    vt[7]  = '{W'(-8), W'(1),  W'(-8), 1'b1};
    vt[8]  = '{W'(0),  W'(-8), W'(7),  1'b1};
    vt[9]  = '{W'(-8), W'(0),  W'(-8), 1'b0};
    vt[10] = '{W'(5),  W'(-2), W'(7),  1'b0};
    vt[11] = '{W'(5),  W'(-3), W'(7),  1'b1};

    rst_n    = 1'b0;
    up_vld   = 1'b0;
    down_rdy = 1'b0;
    a        = '0;
    b        = '0;
    #12;
    chk("rst_down_vld", int'(down_vld), 0);
    chk("rst_diff", int'(diff), 0);
    chk("rst_sat", int'(sat), 0);
    chk("rst_up_rdy", int'(up_rdy), 1);
`ifdef SIGNED_SUB_SAT_COUNT_EN
    chk("rst_sat_cnt", int'(sat_cnt), 0);
`endif
    #10;
    rst_n = 1'b1;
    chk("post_rst_up_rdy", int'(up_rdy), 1);

    // Directed table with two-cycle latency check.
    foreach (vt[i]) begin
      drive_cycle(1'b1, vt[i].a, vt[i].b, 1'b1);
      drive_cycle(1'b0, '0, '0, 1'b1);
      chk("lat1_down_vld", int'(down_vld), 0);
      drive_cycle(1'b0, '0, '0, 1'b1);
      chk("lat2_down_vld", int'(down_vld), 1);
      chk("vec_diff", int'(diff), int'(vt[i].d));
      chk("vec_sat", int'(sat), int'(vt[i].s));
    end
    drain();

    // Back-to-back stream of 8 pairs with a 3-cycle consumer stall.
    delivered = 0;
    idx = 0;
    for (int c = 0; c < 40 && idx < 8; c++) begin
      drive_cycle(1'b1, W'(idx * 3 - 7), W'(5 - idx * 2), !(c >= 4 && c <= 6));
      if (c >= 4 && c <= 6) chk("stall_up_rdy", int'(up_rdy), 0);
      if (up_rdy) idx++;
    end
    chk("stream_accepted", idx, 8);
    drain();
    chk("stream_delivered", delivered, 8);

    // Reset with two results in flight.
    drive_cycle(1'b1, W'(3), W'(-5), 1'b0);
    drive_cycle(1'b1, W'(1), W'(2), 1'b0);
    @(posedge clk);
    #1;
    up_vld = 1'b0;
    chk("pre_rst_down_vld", int'(down_vld), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_down_vld", int'(down_vld), 0);
    chk("async_rst_up_rdy", int'(up_rdy), 1);
    chk("async_rst_sat", int'(sat), 0);
    q.delete();
`ifdef SIGNED_SUB_SAT_COUNT_EN
    chk("async_rst_sat_cnt", int'(sat_cnt), 0);
    exp_cnt = 0;
`endif
    #15;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive_cycle(1'b0, '0, '0, 1'b1);
      chk("no_stale_result", int'(down_vld), 0);
    end

    // Exhaustive sweep of every operand pair.
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) drive_cycle(1'b1, W'(i), W'(j), 1'b1);
    drain();

    // Randomized traffic with random bubbles and back-pressure.
    for (int k = 0; k < 800; k++)
      drive_cycle($urandom_range(0, 9) < 7, W'($urandom), W'($urandom), $urandom_range(0, 9) < 6);
    drain();

`ifdef SIGNED_SUB_SAT_COUNT_EN
    for (int k = 0; k < 300; k++) drive_cycle(1'b1, W'(7), W'(-1), 1'b1);
    drain();
    chk("sat_cnt_full", int'(sat_cnt), 255);
    for (int k = 0; k < 5; k++) drive_cycle(1'b1, W'(7), W'(-1), 1'b1);
    drain();
    chk("sat_cnt_hold", int'(sat_cnt), 255);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
